// File: rtl/module_data_arbiter.sv
// -----------------------------------------------------------------------------
// module_data_arbiter
//
// Round-robin arbiter that merges NMODULES frontend word streams into a single
// registered output stream (e.g. towards an ethernet fifo). A requester keeps
// its grant for up to BURST beats. It gives the grant up earlier when it stops
// offering data while the output slot is free, or when its enable bit drops.
//
// Ports:
//   clk        - system clock; all logic runs on its rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - per-module word available
//   in_ready   - per-module word accepted (only the granted bit can be set)
//   in_data    - packed words; module i occupies [i*LENGTH +: LENGTH]
//   en_mask    - per-module grant enable
//   out_valid  - registered output word valid
//   out_ready  - downstream accepts the output word
//   out_data   - registered output word
//   out_src    - index of the module that sourced out_data
// -----------------------------------------------------------------------------
module module_data_arbiter #(
    parameter int NMODULES = 4,
    parameter int LENGTH   = 128,
    parameter int BURST    = 8,
    localparam int IDXW    = (NMODULES > 1) ? $clog2(NMODULES) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NMODULES-1:0]          in_valid,
    output logic [NMODULES-1:0]          in_ready,
    input  logic [NMODULES*LENGTH-1:0]   in_data,
    input  logic [NMODULES-1:0]          en_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH-1:0]            out_data,
    output logic [IDXW-1:0]              out_src
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    state_t              state_reg;
    logic [IDXW-1:0]     g_reg;
    logic [IDXW-1:0]     p_reg;
    logic [7:0]          beat_reg;
    logic                out_valid_reg;
    logic [LENGTH-1:0]   out_data_reg;
    logic [IDXW-1:0]     out_src_reg;

    logic [NMODULES-1:0] req;
    logic [LENGTH-1:0]   word [NMODULES];

    logic                slot_free;
    logic                accept_ok;
    logic                hs;
    logic                rel_grant;

    logic                sel_found;
    logic [IDXW-1:0]     sel_idx;
    int                  cand;
    logic [IDXW-1:0]     cand_idx;

    // The output register can take a word when it is empty or being drained.
    assign slot_free = ~out_valid_reg | out_ready;
    assign accept_ok = (state_reg == ST_GRANT) & en_mask[g_reg] & slot_free;
    assign hs        = accept_ok & in_valid[g_reg];

    // A stalled output with data still pending is not treated as idling, so
    // the "valid dropped" release only applies while the slot is free.
    assign rel_grant = (hs & (beat_reg == BURST_LAST))
                     | (~in_valid[g_reg] & slot_free)
                     | ~en_mask[g_reg];

    generate
        for (genvar gi = 0; gi < NMODULES; gi++) begin : g_lane
            assign req[gi]      = in_valid[gi] & en_mask[gi];
            assign word[gi]     = in_data[gi*LENGTH +: LENGTH];
            assign in_ready[gi] = accept_ok & (g_reg == IDXW'(gi));
        end
    endgenerate

    // Round-robin search starting just after the last-served module.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NMODULES; k++) begin
            cand     = (int'(p_reg) + k) % NMODULES;
            cand_idx = IDXW'(cand);
            if (!sel_found && req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            p_reg         <= IDXW'(NMODULES - 1);
            g_reg         <= '0;
            beat_reg      <= 8'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_found) begin
                        g_reg     <= sel_idx;
                        beat_reg  <= 8'd0;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hs) begin
                        beat_reg <= beat_reg + 8'd1;
                    end
                    if (rel_grant) begin
                        state_reg <= ST_IDLE;
                        p_reg     <= g_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Loading and draining in the same cycle keeps out_valid high,
            // so a continuous stream has no bubbles.
            if (hs) begin
                out_data_reg  <= word[g_reg];
                out_src_reg   <= g_reg;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule

// File: doc/module_data_arbiter.md
MODULE_DATA_ARBITER -- requirements
Module: module_data_arbiter

Interface
REQ-001 SHALL have parameter NMODULES, default 4: number of frontend data requesters.
REQ-002 SHALL have parameter LENGTH, default 128: data word width in bits.
REQ-003 SHALL have parameter BURST, default 8: maximum beats per grant, range 1..256.
REQ-004 SHALL have port clk, input, 1: single clock (sys_clk domain); all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, NMODULES: per-module word available.
REQ-007 SHALL have port in_ready, output, NMODULES: per-module word accepted when set together with in_valid.
REQ-008 SHALL have port in_data, input, NMODULES*LENGTH: module i occupies bits [i*LENGTH +: LENGTH].
REQ-009 SHALL have port en_mask, input, NMODULES: module i may be granted only while en_mask[i]=1.
REQ-010 SHALL have port out_valid, output, 1: registered output word valid.
REQ-011 SHALL have port out_ready, input, 1: downstream (ethernet fifo not full) accepts the word.
REQ-012 SHALL have port out_data, output, LENGTH: registered output word.
REQ-013 SHALL have port out_src, output, clog2(NMODULES): index of the module that sourced out_data.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT, with a grant index g and a last-served pointer p.
REQ-015 SHALL define req[i] = in_valid[i] & en_mask[i].
REQ-016 SHALL, in IDLE, if any req is set, select the first i with req[i]=1 searching p+1, p+2, ... modulo NMODULES, latch it as g, clear the beat count, and enter GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 SHALL drive in_ready[g] = (state==GRANT) & en_mask[g] & (~out_valid | out_ready); all other in_ready bits SHALL be 0.
REQ-018 SHALL, on a handshake (in_valid[g] & in_ready[g]), load out_data with in_data of module g, set out_src = g, and set out_valid = 1 on the next edge (latency 1 cycle).
REQ-019 SHALL clear out_valid when out_ready=1 and no new handshake occurs in the same cycle; a simultaneous drain and load SHALL keep out_valid=1 with the new word, so there are no bubbles.
REQ-020 SHALL hold out_data and out_src stable while out_valid=1 and out_ready=0.
REQ-021 SHALL increment the beat count, width 8 bits, on each handshake in GRANT.
REQ-022 SHALL release the grant (go to IDLE, p <= g) on the edge after any of the following:
- the handshake with beat count == BURST-1;
- in_valid[g]=0 while the output slot is free (~out_valid | out_ready);
- en_mask[g]=0.
REQ-023 SHALL NOT release the grant while the output slot is stalled and in_valid[g]=1; waiting on out_ready is not idling.
REQ-024 SHALL, when en_mask[g] falls mid-burst, accept no further beats from g; an already-registered word SHALL still be delivered.
REQ-025 SHALL wrap the pointer modulo NMODULES, so that after module NMODULES-1 the search restarts at 0.
REQ-026 SHALL give a lone requester back-to-back grants, separated by one IDLE cycle every BURST beats.
REQ-027 SHALL never drop or duplicate a word: every input handshake produces exactly one output handshake, in order.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, p=NMODULES-1 (module 0 searched first), g=0, beat count=0, out_valid=0, out_data=0, out_src=0, and in_ready=0.
REQ-029 SHALL, on reset asserted mid-burst, immediately discard any pending output word; the first grant after release SHALL go to the lowest requesting index.

Verification
REQ-030 SHALL verify: all 4 modules valid continuously, out_ready=1, BURST=8 -> 8 beats from module 0, then 8 from 1, 2, 3, then 0 again; out_src follows; 1 IDLE cycle between bursts.
REQ-031 SHALL verify: only module 2 valid with 3 words, then valid drops -> 3 words out with out_src=2, then IDLE; a later module 1 request is served next.
REQ-032 SHALL verify: out_ready held 0 for 10 cycles mid-burst -> out_valid=1, out_data stable, in_ready=0, no grant change; 1 word per cycle resumes after release.
REQ-033 SHALL verify: en_mask[1] cleared during module 1's 3rd beat -> the registered 3rd word is still delivered, no 4th beat is taken, and the grant moves to the next enabled requester.
REQ-034 SHALL verify: en_mask=4'b0000 with all valid -> in_ready=0 and out_valid=0 indefinitely.
REQ-035 SHALL verify: rst_n pulsed low mid-burst with out_valid=1 -> out_valid=0 at once; after release, all valid -> first out_src=0.
